// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder with LAT wait states in front of a word-wide RAM.
// Optional feature macro DMEM_MISALIGN_TRAP_EN: flag misaligned half/word accesses instead of aligning them.
module dmem_responder #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 128,
  parameter int LAT        = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [2:0]            func3,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_CNT = 4'(LAT);

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DM_ADDRESS-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [2:0]              func3_q, func3_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic [DATA_W-1:0]       rd_data_q, rd_data_d;
  logic                    err_q, err_d;

  logic [DATA_W-1:0]       mem [DEPTH];

  logic                    accept;
  logic                    commit;
  logic                    is_word;
  logic                    is_half;
  logic                    trap;
  logic [1:0]              lane;
  logic [DATA_W-1:0]       word_rd;
  logic [DATA_W-1:0]       word_wr;
  logic                    do_write;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;
  logic [DATA_W-1:0]       load_val;

  assign accept = req_valid && (state_q == ST_IDLE) && (MemRead || MemWrite);

  // Decode the latched request into byte lane, trap flag, merged store word and sized load value.
  always_comb begin
    word_rd = mem[addr_q[DM_ADDRESS-1:2]];
    is_word = (func3_q == 3'b010);
    // A store only knows SH as a half access; func3 101 is LHU for loads only.
    is_half = (func3_q == 3'b001) || (!wr_q && (func3_q == 3'b101));
    lane    = addr_q[1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
    trap = (is_half && addr_q[0]) || (is_word && (addr_q[1:0] != 2'b00));
`else
    trap = 1'b0;
    if (is_word) begin
      lane = 2'b00;
    end else if (is_half) begin
      lane = {addr_q[1], 1'b0};
    end else begin
      lane = addr_q[1:0];
    end
`endif
    byte_sel = word_rd[{lane, 3'b000} +: 8];
    half_sel = word_rd[{lane[1], 4'b0000} +: 16];

    word_wr  = word_rd;
    do_write = 1'b0;
    if (wr_q && !trap) begin
      case (func3_q)
        3'b000: begin
          word_wr[{lane, 3'b000} +: 8] = wdata_q[7:0];
          do_write = 1'b1;
        end
        3'b001: begin
          word_wr[{lane[1], 4'b0000} +: 16] = wdata_q[15:0];
          do_write = 1'b1;
        end
        3'b010: begin
          word_wr  = wdata_q;
          do_write = 1'b1;
        end
        default: do_write = 1'b0;
      endcase
    end else begin
      do_write = 1'b0;
    end

    load_val = {DATA_W{1'b0}};
    if (rd_q && !wr_q && !trap) begin
      case (func3_q)
        3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
        3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
        3'b010:  load_val = word_rd;
        3'b100:  load_val = {24'h000000, byte_sel};
        3'b101:  load_val = {16'h0000, half_sel};
        default: load_val = {DATA_W{1'b0}};
      endcase
    end else begin
      load_val = {DATA_W{1'b0}};
    end
  end

  // Next-state logic: latch on accept, count wait states, sample/commit on WAIT->RESP.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    func3_d   = func3_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    rd_data_d = {DATA_W{1'b0}};
    err_d     = 1'b0;
    commit    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WAIT;
          cnt_d   = LAT_CNT;
          addr_d  = addr;
          wdata_d = wr_data;
          func3_d = func3;
          rd_d    = MemRead;
          wr_d    = MemWrite;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d   = ST_RESP;
          commit    = 1'b1;
          rd_data_d = load_val;
          err_d     = trap;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= {DM_ADDRESS{1'b0}};
      wdata_q   <= {DATA_W{1'b0}};
      func3_q   <= 3'b000;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      rd_data_q <= {DATA_W{1'b0}};
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      func3_q   <= func3_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
    end
  end

  // RAM write port; contents survive reset but a commit coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (reset && commit && do_write) begin
      mem[addr_q[DM_ADDRESS-1:2]] <= word_wr;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rd_data   = rd_data_q;
  assign err       = err_q;

endmodule
